// File: rtl/operand_sequencer_if.sv
// Byte-stream input, combine-unit bus and result-stream output
// bundled for the operand sequencer.
interface operand_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_mode;
    logic       start;
    logic       mode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] d;
    logic [7:0] result;
    logic       done;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       timeout;

    modport master (
        output in_valid, in_data, in_mode,
        input  in_ready,
        input  start, mode, a, b, c, d,
        output result, done,
        input  out_valid, out_data, timeout,
        output out_ready
    );

    modport slave (
        input  in_valid, in_data, in_mode,
        output in_ready,
        output start, mode, a, b, c, d,
        input  result, done,
        output out_valid, out_data, timeout,
        input  out_ready
    );
endinterface

// File: rtl/operand_sequencer.sv
// Collects four operand bytes, runs the combine unit with a
// watchdog, and hands the captured result to a valid/ready sink.
module operand_sequencer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input logic            clock,
    input logic            reset,
    operand_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_COLLECT,
        S_WAIT,
        S_OUT
    } state_t;

    localparam logic [CNT_W-1:0] LAST =
        CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_n;
    logic [1:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       a_q;
    logic [7:0]       b_q;
    logic [7:0]       c_q;
    logic [7:0]       d_q;
    logic             mode_q;
    logic [7:0]       out_q;
    logic             tmo_q;

    logic in_ready;
    logic start;
    logic out_valid;
    logic accept;
    logic finish;
    logic abandon;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_COLLECT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        start     = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        finish    = 1'b0;
        abandon   = 1'b0;
        unique case (state)
            S_COLLECT: begin
                in_ready = 1'b1;
                accept   = bus.in_valid;
                if (accept && idx == 2'd3) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                start = 1'b1;
                // done on the last counted edge still wins
                if (bus.done) begin
                    finish  = 1'b1;
                    state_n = S_OUT;
                end else if (cnt == LAST) begin
                    abandon = 1'b1;
                    state_n = S_COLLECT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_n = S_COLLECT;
                end
            end
            default: begin
                state_n = S_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx    <= '0;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            d_q    <= '0;
            mode_q <= 1'b0;
            out_q  <= '0;
            tmo_q  <= 1'b0;
        end else begin
            if (accept) begin
                // index wraps to 0 after byte d
                idx <= idx + 2'd1;
                unique case (idx)
                    2'd0: a_q <= bus.in_data;
                    2'd1: b_q <= bus.in_data;
                    2'd2: c_q <= bus.in_data;
                    2'd3: begin
                        d_q    <= bus.in_data;
                        mode_q <= bus.in_mode;
                        cnt    <= '0;
                    end
                    default: ;
                endcase
            end
            if (state == S_WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (finish) begin
                out_q <= bus.result;
            end
            if (abandon) begin
                tmo_q <= 1'b1;
                idx   <= '0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.start     = start;
    assign bus.out_valid = out_valid;
    assign bus.mode      = mode_q;
    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.c         = c_q;
    assign bus.d         = d_q;
    assign bus.out_data  = out_q;
    assign bus.timeout   = tmo_q;
endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer with a hand-driven
// combine stub and hand-computed expectations.
module tb_operand_sequencer;
    logic clock;
    logic reset;
    int   checks;
    int   errors;
    int   n;

    operand_sequencer_if bus ();

    operand_sequencer #(
        .TIMEOUT_CYCLES(16),
        .CNT_W(5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(
        input logic [7:0] v,
        input logic       m
    );
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        bus.in_mode  = m;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic feed(
        input logic [7:0] v0,
        input logic [7:0] v1,
        input logic [7:0] v2,
        input logic [7:0] v3,
        input logic       m
    );
        send(v0, 1'b0);
        send(v1, 1'b0);
        send(v2, 1'b0);
        send(v3, m);
    endtask

    // k = WAIT cycle (1-based) in which done is raised, 0 = never
    task automatic wait_done(
        input  int         k,
        input  logic [7:0] r,
        output int         cyc
    );
        cyc = 0;
        while (bus.start && cyc < 40) begin
            cyc++;
            if (cyc == k) begin
                bus.done   = 1'b1;
                bus.result = r;
            end
            tick();
            bus.done = 1'b0;
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = 1'b0;
        bus.result    = '0;
        bus.done      = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_start", bus.start, 0);
        chk("rst_ovalid", bus.out_valid, 0);
        chk("rst_tmo", bus.timeout, 0);
        chk("rst_iready", bus.in_ready, 1);
        chk("rst_odata", bus.out_data, 0);
        reset = 1'b0;
        tick();

        // reset two cycles into WAIT
        feed(8'h01, 8'h02, 8'hFF, 8'hFE, 1'b0);
        tick();
        tick();
        chk("t1_start", bus.start, 1);
        chk("t1_a", bus.a, 8'h01);
        reset = 1'b1;
        #1;
        chk("t1_start0", bus.start, 0);
        chk("t1_ov0", bus.out_valid, 0);
        chk("t1_tmo0", bus.timeout, 0);
        chk("t1_abcd", {bus.a, bus.b, bus.c, bus.d}, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("t1_iready", bus.in_ready, 1);
        chk("t1_ov", bus.out_valid, 0);

        // nominal
        feed(8'h01, 8'h02, 8'hFF, 8'hFE, 1'b0);
        chk("t2_abcd", {bus.a, bus.b, bus.c, bus.d},
            32'h0102FFFE);
        chk("t2_mode", bus.mode, 0);
        chk("t2_start", bus.start, 1);
        wait_done(3, 8'h5A, n);
        chk("t2_startcyc", n, 3);
        chk("t2_ov", bus.out_valid, 1);
        chk("t2_odata", bus.out_data, 8'h5A);
        chk("t2_iready", bus.in_ready, 0);
        drain();
        chk("t2_ov0", bus.out_valid, 0);
        chk("t2_iready1", bus.in_ready, 1);

        // backpressure
        feed(8'hFE, 8'h01, 8'h01, 8'h04, 1'b1);
        chk("t3_mode", bus.mode, 1);
        wait_done(1, 8'hC3, n);
        chk("t3_startcyc", n, 1);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hAA;
            tick();
            chk("t3_odata", bus.out_data, 8'hC3);
            chk("t3_iready", bus.in_ready, 0);
            chk("t3_ov", bus.out_valid, 1);
        end
        bus.in_valid = 1'b0;
        drain();
        chk("t3_ov0", bus.out_valid, 0);
        chk("t3_a", bus.a, 8'hFE);
        bus.done   = 1'b1;
        bus.result = 8'h99;
        tick();
        bus.done = 1'b0;
        chk("t3_strayd", bus.out_valid, 0);
        chk("t3_keep", bus.out_data, 8'hC3);

        // gapped input; out_ready already high at done
        send(8'h01, 1'b0);
        tick();
        send(8'hFF, 1'b0);
        tick();
        send(8'hFF, 1'b0);
        tick();
        chk("t4_nostart", bus.start, 0);
        chk("t4_iready", bus.in_ready, 1);
        send(8'hFF, 1'b0);
        chk("t4_abcd", {bus.a, bus.b, bus.c, bus.d},
            32'h01FFFFFF);
        chk("t4_start", bus.start, 1);
        bus.out_ready = 1'b1;
        wait_done(2, 8'h11, n);
        chk("t4_ov", bus.out_valid, 1);
        chk("t4_odata", bus.out_data, 8'h11);
        tick();
        bus.out_ready = 1'b0;
        chk("t4_ov0", bus.out_valid, 0);

        // timeout
        feed(8'hFF, 8'h01, 8'hFF, 8'h01, 1'b0);
        wait_done(0, 8'h00, n);
        chk("t5_cyc", n, 16);
        chk("t5_tmo", bus.timeout, 1);
        chk("t5_ov", bus.out_valid, 0);
        chk("t5_iready", bus.in_ready, 1);
        feed(8'h10, 8'h20, 8'h30, 8'h40, 1'b1);
        chk("t5_abcd", {bus.a, bus.b, bus.c, bus.d},
            32'h10203040);
        chk("t5_start", bus.start, 1);
        wait_done(1, 8'h33, n);
        chk("t5_odata", bus.out_data, 8'h33);
        drain();
        chk("t5_sticky", bus.timeout, 1);

        // done on the last counted edge
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("t6_tmo0", bus.timeout, 0);
        feed(8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b0);
        wait_done(16, 8'h7E, n);
        chk("t6_cyc", n, 16);
        chk("t6_ov", bus.out_valid, 1);
        chk("t6_odata", bus.out_data, 8'h7E);
        chk("t6_tmo", bus.timeout, 0);
        drain();
        chk("t6_ov0", bus.out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
